// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver feeding a first-word-fall-through receive FIFO.
// A 2-flop synchroniser produces rxs; a five-state FSM validates the start bit, samples each
// data bit mid-period and checks the stop bit. Good frames are pushed into the FIFO. Framing,
// overrun and parity errors are held in sticky flags.
// Optional feature: define UART_RX_PARITY_EN to receive one parity bit after the data bits.
// PARITY_ODD selects odd or even parity. Without the macro, parity_err is tied low.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             RxD,
    input  logic                             baud_tick,
    input  logic                             receiver_enable,
    input  logic                             rd_en,
    input  logic                             err_clr,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic                             RDA,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             framing_err,
    output logic                             overrun,
    output logic                             parity_err
);

    localparam int unsigned TcntW = $clog2(OVERSAMPLE);
    localparam int unsigned BcntW = $clog2(DATA_BITS + 1);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

    // Terminal tick counts: the start bit is re-checked half a bit in, all others a full bit.
    localparam logic [TcntW-1:0] TcntHalf = TcntW'(OVERSAMPLE / 2 - 1);
    localparam logic [TcntW-1:0] TcntFull = TcntW'(OVERSAMPLE - 1);
    localparam logic [BcntW-1:0] BcntLast = BcntW'(DATA_BITS - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic                 rx_meta_q, rxs_q;
    state_e               state_q, state_d;
    logic [TcntW-1:0]     tcnt_q, tcnt_d;
    logic [BcntW-1:0]     bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 push, set_fe;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 pop, full, wr_ok, set_ovr;
    logic                 fe_q, ovr_q;

`ifdef UART_RX_PARITY_EN
    localparam logic ParOdd = (PARITY_ODD != 0);
    logic par_bad_q, par_bad_d;
    logic set_pe;
    logic pe_q;
`endif

    // Two-flop synchroniser; idle-high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= RxD;
            rxs_q     <= rx_meta_q;
        end
    end

    // Receiver FSM state and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state logic: tick counting, bit sampling and push/error decisions.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        set_fe  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        set_pe    = 1'b0;
`endif
        if ((state_q != StIdle) && !receiver_enable) begin
            // Abort silently: the partial frame is dropped without flagging anything.
            state_d = StIdle;
            tcnt_d  = '0;
            bcnt_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!rxs_q && receiver_enable) begin
                        state_d = StStart;
                        tcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end
                end
                StStart: begin
                    if (baud_tick) begin
                        if (tcnt_q == TcntHalf) begin
                            tcnt_d = '0;
                            bcnt_d = '0;
                            // A high level here means the low pulse was a glitch.
                            state_d = rxs_q ? StIdle : StData;
                        end else begin
                            tcnt_d = tcnt_q + TcntW'(1);
                        end
                    end
                end
                StData: begin
                    if (baud_tick) begin
                        if (tcnt_q == TcntFull) begin
                            tcnt_d  = '0;
                            shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                            bcnt_d  = bcnt_q + BcntW'(1);
                            if (bcnt_q == BcntLast) begin
`ifdef UART_RX_PARITY_EN
                                state_d = StParity;
`else
                                state_d = StStop;
`endif
                            end
                        end else begin
                            tcnt_d = tcnt_q + TcntW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (baud_tick) begin
                        if (tcnt_q == TcntFull) begin
                            tcnt_d    = '0;
                            par_bad_d = ((^shreg_q) ^ rxs_q) != ParOdd;
                            state_d   = StStop;
                        end else begin
                            tcnt_d = tcnt_q + TcntW'(1);
                        end
                    end
                end
`endif
                StStop: begin
                    if (baud_tick) begin
                        if (tcnt_q == TcntFull) begin
                            tcnt_d  = '0;
                            state_d = StIdle;
                            set_fe  = !rxs_q;
`ifdef UART_RX_PARITY_EN
                            set_pe = par_bad_q;
                            push   = rxs_q && !par_bad_q;
`else
                            push   = rxs_q;
`endif
                        end else begin
                            tcnt_d = tcnt_q + TcntW'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FIFO control: a push at full only succeeds when a pop frees the head in the same cycle.
    always_comb begin
        pop     = rd_en && (count_q != '0);
        full    = (count_q == CntFull);
        wr_ok   = push && (!full || pop);
        set_ovr = push && full && !pop;
        count_d = count_q;
        if (wr_ok && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!wr_ok && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    // FIFO storage; contents need no reset because the output is gated by occupancy.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= shreg_q;
    end

    // Sticky error flags; a new error in the clearing cycle takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            fe_q  <= 1'b0;
            ovr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q  <= 1'b0;
`endif
        end else begin
            fe_q  <= set_fe  ? 1'b1 : (err_clr ? 1'b0 : fe_q);
            ovr_q <= set_ovr ? 1'b1 : (err_clr ? 1'b0 : ovr_q);
`ifdef UART_RX_PARITY_EN
            pe_q  <= set_pe  ? 1'b1 : (err_clr ? 1'b0 : pe_q);
`endif
        end
    end

    // First-word-fall-through head and status outputs.
    always_comb begin
        RDA         = (count_q != '0);
        rx_data     = RDA ? mem_q[rd_ptr_q] : '0;
        fifo_count  = count_q;
        framing_err = fe_q;
        overrun     = ovr_q;
`ifdef UART_RX_PARITY_EN
        parity_err  = pe_q;
`else
        parity_err  = 1'b0;
`endif
    end

endmodule
